fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word-address requests to instruction memory and
// hands fetched words to the IF/ID register, absorbing stalls and branch redirects.
module fetch_unit #(
  parameter logic [0:29] RESET_PC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [0:29] redirect_pc,
  output logic        imem_req,
  output logic [0:29] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_data,
  output logic [0:31] instruction_out,
  output logic [0:29] pc_4_out,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic [1:0]  dbg_state
);

  // REQ: request in flight for pc. HOLD: word parked while decode stalls.
  // KILL: an abandoned request at kill_addr must still see its ack before moving on.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [0:29] pc_q, pc_d;
  logic [0:29] kill_addr_q, kill_addr_d;
  logic [0:31] hold_instr_q, hold_instr_d;
  logic [0:29] hold_pc4_q, hold_pc4_d;
  logic [0:29] pc_inc;

  assign pc_inc    = pc_q + 30'd1;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      kill_addr_q  <= '0;
      hold_instr_q <= '0;
      hold_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_addr_q  <= kill_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_addr_d  = kill_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    case (state_q)
      ST_REQ: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // Without the ack yet, the old request must stay on the bus until it lands.
          if (!imem_ack) begin
            kill_addr_d = pc_q;
            state_d     = ST_KILL;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            hold_instr_d = imem_data;
            hold_pc4_d   = pc_inc;
            state_d      = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (!stall) begin
          state_d = ST_REQ;
        end
      end
      ST_KILL: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    ifid_we         = 1'b0;
    ifid_flush      = 1'b0;
    instruction_out = '0;
    pc_4_out        = '0;
    if (rst) begin
      ifid_flush = redirect;
      case (state_q)
        ST_HOLD: begin
          instruction_out = hold_instr_q;
          pc_4_out        = hold_pc4_q;
          ifid_we         = !redirect && !stall;
        end
        ST_KILL: begin
          imem_req        = 1'b1;
          imem_addr       = kill_addr_q;
          instruction_out = imem_data;
          pc_4_out        = pc_inc;
        end
        default: begin
          imem_req        = 1'b1;
          instruction_out = imem_data;
          pc_4_out        = pc_inc;
          ifid_we         = imem_ack && !redirect && !stall;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written async-reset sequence,
// and randomized traffic scored against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [29:0] RESET_PC = 30'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [0:29] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic [0:31] imem_data = '0;
  logic        imem_req;
  logic [0:29] imem_addr;
  logic [0:31] instruction_out;
  logic [0:29] pc_4_out;
  logic        ifid_we;
  logic        ifid_flush;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instruction_out(instruction_out),
    .pc_4_out(pc_4_out), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic        rst, stall, redirect, ack;
    logic [29:0] rpc;
    logic [31:0] data;
    logic        req, chk_addr;
    logic [29:0] addr;
    logic        we, flush;
    logic [31:0] instr;
    logic [29:0] pc4;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [29:0] pc4;
  } held_t;

  vec_t tbl[$];

  // Reference model: next fetch pc, a parked word awaiting decode, and an
  // abandoned request whose late reply must be swallowed.
  logic [29:0] m_pc;
  held_t       m_held[$];
  bit          m_orphan;
  logic [29:0] m_orphan_addr;

  function automatic vec_t mk(logic r, logic s, logic rd, logic a, logic [29:0] p,
                              logic [31:0] d, logic e_req, logic e_ca, logic [29:0] e_addr,
                              logic e_we, logic e_fl, logic [31:0] e_in, logic [29:0] e_p4);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.ack = a; v.rpc = p; v.data = d;
    v.req = e_req; v.chk_addr = e_ca; v.addr = e_addr; v.we = e_we; v.flush = e_fl;
    v.instr = e_in; v.pc4 = e_p4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic a,
                       input logic [29:0] p, input logic [31:0] d);
    @(negedge clk);
    cyc++;
    rst = r; stall = s; redirect = rd; redirect_pc = p; imem_ack = a; imem_data = d;
    #1;
  endtask

  task automatic check_outputs(input logic e_req, input logic e_ca, input logic [29:0] e_addr,
                               input logic e_we, input logic e_fl, input logic [31:0] e_in,
                               input logic [29:0] e_p4);
    chk("imem_req", imem_req, e_req);
    if (e_ca) chk("imem_addr", imem_addr, e_addr);
    chk("ifid_we", ifid_we, e_we);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("instruction_out", instruction_out, e_in);
    chk("pc_4_out", pc_4_out, e_p4);
  endtask

  task automatic model_check();
    logic e_req, e_ca, e_we, e_fl;
    logic [29:0] e_addr, e_p4;
    logic [31:0] e_in;
    e_req = 0; e_ca = 0; e_addr = '0; e_we = 0; e_fl = 0; e_in = '0; e_p4 = '0;
    if (rst) begin
      e_fl = redirect;
      e_ca = 1;
      if (m_held.size() != 0) begin
        e_addr = m_pc;
        e_in   = m_held[0].instr;
        e_p4   = m_held[0].pc4;
        e_we   = !redirect && !stall;
      end else begin
        e_req  = 1;
        e_addr = m_orphan ? m_orphan_addr : m_pc;
        e_in   = imem_data;
        e_p4   = m_pc + 30'd1;
        e_we   = !m_orphan && imem_ack && !redirect && !stall;
      end
    end
    check_outputs(e_req, e_ca, e_addr, e_we, e_fl, e_in, e_p4);
  endtask

  task automatic model_advance();
    held_t h;
    if (!rst) begin
      m_pc = RESET_PC; m_held.delete(); m_orphan = 0;
    end else if (m_held.size() != 0) begin
      if (redirect) begin
        m_pc = redirect_pc; m_held.delete();
      end else if (!stall) begin
        m_held.delete();
      end
    end else if (m_orphan) begin
      if (redirect) m_pc = redirect_pc;
      if (imem_ack) m_orphan = 0;
    end else if (redirect) begin
      if (!imem_ack) begin
        m_orphan = 1; m_orphan_addr = m_pc;
      end
      m_pc = redirect_pc;
    end else if (imem_ack) begin
      if (stall) begin
        h.instr = imem_data; h.pc4 = m_pc + 30'd1;
        m_held.push_back(h);
      end
      m_pc = m_pc + 30'd1;
    end
  endtask

  initial begin
    // rst stall red ack rpc data | req chk addr we flush instr pc4
    tbl.push_back(mk(0,0,1,1,30'h5,32'hFFFF_FFFF, 0,0,30'h0, 0,0,32'h0,30'h0));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h0, 1,1,30'h0, 1,0,32'h0,30'h1));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h1, 1,1,30'h1, 1,0,32'h1,30'h2));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h2, 1,1,30'h2, 1,0,32'h2,30'h3));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h3, 1,1,30'h3, 1,0,32'h3,30'h4));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h4, 1,1,30'h4, 1,0,32'h4,30'h5));
    tbl.push_back(mk(1,1,0,1,30'h0,32'hDEAD_BEEF, 1,1,30'h5, 0,0,32'hDEAD_BEEF,30'h6));
    tbl.push_back(mk(1,1,0,0,30'h0,32'h0, 0,1,30'h6, 0,0,32'hDEAD_BEEF,30'h6));
    tbl.push_back(mk(1,1,0,1,30'h0,32'h99, 0,1,30'h6, 0,0,32'hDEAD_BEEF,30'h6));
    tbl.push_back(mk(1,1,0,0,30'h0,32'h0, 0,1,30'h6, 0,0,32'hDEAD_BEEF,30'h6));
    tbl.push_back(mk(1,0,0,0,30'h0,32'h0, 0,1,30'h6, 1,0,32'hDEAD_BEEF,30'h6));
    tbl.push_back(mk(1,0,0,0,30'h0,32'h0, 1,1,30'h6, 0,0,32'h0,30'h7));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h6, 1,1,30'h6, 1,0,32'h6,30'h7));
    tbl.push_back(mk(1,0,1,0,30'h100,32'h0, 1,1,30'h7, 0,1,32'h0,30'h8));
    tbl.push_back(mk(1,0,0,0,30'h0,32'h0, 1,1,30'h7, 0,0,32'h0,30'h101));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h55, 1,1,30'h7, 0,0,32'h55,30'h101));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h100, 1,1,30'h100, 1,0,32'h100,30'h101));
    tbl.push_back(mk(1,0,1,1,30'h200,32'hAAAA, 1,1,30'h101, 0,1,32'hAAAA,30'h102));
    tbl.push_back(mk(1,1,0,1,30'h0,32'h200, 1,1,30'h200, 0,0,32'h200,30'h201));
    tbl.push_back(mk(1,1,1,0,30'h3FFF_FFFF,32'h0, 0,1,30'h201, 0,1,32'h200,30'h201));
    tbl.push_back(mk(1,0,0,1,30'h0,32'h1234_5678, 1,1,30'h3FFF_FFFF, 1,0,32'h1234_5678,30'h0));
    tbl.push_back(mk(1,0,0,0,30'h0,32'h0, 1,1,30'h0, 0,0,32'h0,30'h1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redirect, tbl[i].ack, tbl[i].rpc, tbl[i].data);
      check_outputs(tbl[i].req, tbl[i].chk_addr, tbl[i].addr, tbl[i].we, tbl[i].flush,
                    tbl[i].instr, tbl[i].pc4);
    end

    // Asynchronous reset while an abandoned request is still waiting for its ack.
    drive(1,0,1,1,30'h40,32'h0);
    drive(1,0,1,0,30'h50,32'h0);
    drive(1,0,0,0,30'h0,32'h0);
    chk("kill_req", imem_req, 1'b1);
    chk("kill_addr", imem_addr, 30'h40);
    #2;
    redirect = 1; imem_ack = 1; imem_data = 32'hCAFE_F00D;
    rst = 0;
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_we", ifid_we, 1'b0);
    chk("rst_flush", ifid_flush, 1'b0);
    chk("rst_instr", instruction_out, 32'h0);
    chk("rst_pc4", pc_4_out, 30'h0);
    drive(1,0,0,0,30'h0,32'h0);
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, RESET_PC);
    chk("post_rst_we", ifid_we, 1'b0);
    drive(1,0,0,1,30'h0,32'h77);
    chk("post_rst_ack_we", ifid_we, 1'b1);
    chk("post_rst_ack_instr", instruction_out, 32'h77);
    chk("post_rst_ack_pc4", pc_4_out, RESET_PC + 30'd1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rd, a;
      logic [29:0] p;
      r  = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 9) == 0);
      a  = ($urandom_range(0, 1) == 1);
      p  = ($urandom_range(0, 3) == 0) ? (30'h3FFF_FFFF - 30'($urandom_range(0, 2)))
                                       : 30'($urandom);
      drive(r, s, rd, a, p, $urandom);
      model_check();
      model_advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
